// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: FIFO entry layout and the
// hard-wired zero register index.
package wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'h1 << rd;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of pipeline, multi-cycle and register-file write signals.
// With WB_BYPASS_EN defined it also carries the forwarding bypass outputs.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
);
  logic                     pipe_valid;
  logic [4:0]               pipe_rd;
  logic [DW-1:0]            pipe_data;
  logic                     mc_valid;
  logic                     mc_ready;
  logic [4:0]               mc_rd;
  logic [DW-1:0]            mc_data;
  logic                     RegWrite;
  logic [4:0]               WriteRegister;
  logic [DW-1:0]            WriteData;
  logic [31:0]              pending_mask;
  logic [$clog2(DEPTH):0]   fifo_count;
`ifdef WB_BYPASS_EN
  logic                     bypass_valid;
  logic [4:0]               bypass_rd;
  logic [DW-1:0]            bypass_data;
`endif

  // Driver side: the pipeline / multi-cycle unit and register-file consumer.
  modport master (
    output pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, RegWrite, WriteRegister, WriteData, pending_mask, fifo_count
`ifdef WB_BYPASS_EN
    , input bypass_valid, bypass_rd, bypass_data
`endif
  );

  // Arbiter side.
  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    output mc_ready, RegWrite, WriteRegister, WriteData, pending_mask, fifo_count
`ifdef WB_BYPASS_EN
    , output bypass_valid, bypass_rd, bypass_data
`endif
  );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer of multi-cycle results. Entries are exposed so the parent
// can squash older writes and build the pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  input  logic [DEPTH-1:0]            squash,
  output wb_entry_t [DEPTH-1:0]       entries,
  output wb_entry_t                   head,
  output logic [$clog2(DEPTH):0]      count,
  output logic [$clog2(DEPTH):0]      count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // A valid bit is only ever set by a push, and is cleared on pop or squash,
  // so valid implies "occupied and still live".
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash[i]) mem_d[i].valid = 1'b0;
    end
    if (pop)  mem_d[rd_ptr_q].valid = 1'b0;
    if (push) mem_d[wr_ptr_q] = push_entry;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign entries    = mem_q;
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the non-stalling pipeline writeback and the queued multi-cycle results
// onto the register-file write port. Optional bypass outputs: WB_BYPASS_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_write_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [DEPTH-1:0]      squash;
  logic [31:0]           entry_mask [DEPTH];
  logic [31:0]           pending;
  logic                  pipe_ok;
  logic                  push;
  logic                  pop;

  logic                  regwrite_q, regwrite_d;
  logic [4:0]            wr_reg_q, wr_reg_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  mc_ready_q, mc_ready_d;

  // A write to the zero register is dropped and frees the port for the FIFO.
  assign pipe_ok = bus.pipe_valid && (bus.pipe_rd != REG_ZERO);
  assign push    = bus.mc_valid && mc_ready_q && (bus.mc_rd != REG_ZERO);
  assign pop     = !pipe_ok && (count != '0);

  assign push_entry = '{valid: 1'b1, rd: bus.mc_rd, data: 64'(bus.mc_data)};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // The pipe result is younger than anything queued for the same register.
    assign squash[gi]     = pipe_ok && entries[gi].valid && (entries[gi].rd == bus.pipe_rd);
    assign entry_mask[gi] = entries[gi].valid ? rd_onehot(entries[gi].rd) : 32'h0;
  end

  always_comb begin
    pending = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending | entry_mask[i];
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash     (squash),
    .entries    (entries),
    .head       (head),
    .count      (count),
    .count_next (count_next)
  );

  // Squashed heads pop silently; address and data keep their last values.
  always_comb begin
    regwrite_d = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    if (pipe_ok) begin
      regwrite_d = 1'b1;
      wr_reg_d   = bus.pipe_rd;
      wr_data_d  = bus.pipe_data;
    end else if (pop && head.valid) begin
      regwrite_d = 1'b1;
      wr_reg_d   = head.rd;
      wr_data_d  = DW'(head.data);
    end
    mc_ready_d = (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regwrite_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      mc_ready_q <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      mc_ready_q <= mc_ready_d;
    end
  end

  assign bus.RegWrite      = regwrite_q;
  assign bus.WriteRegister = wr_reg_q;
  assign bus.WriteData     = wr_data_q;
  assign bus.mc_ready      = mc_ready_q;
  assign bus.pending_mask  = pending;
  assign bus.fifo_count    = count;

`ifdef WB_BYPASS_EN
  assign bus.bypass_valid = regwrite_d;
  assign bus.bypass_rd    = wr_reg_d;
  assign bus.bypass_data  = wr_data_d;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// queue-based model of the arbitration rules.
module tb_wb_write_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .DW(DW)) bus();

  wb_write_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: queue in arrival order; live=0 marks a result superseded by the pipe.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          live;
  } m_entry_t;

  m_entry_t    q[$];
  bit          m_we;
  bit          m_ready;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;

  function automatic logic [31:0] m_pending();
    logic [31:0] m = 32'h0;
    foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic step(input bit rstn, input bit pv, input logic [4:0] prd, input logic [63:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [63:0] md);
    bit       pipe_ok;
    bit       accept;
    m_entry_t h;
    reset_n        = rstn;
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pd;
    bus.mc_valid   = mv;
    bus.mc_rd      = mrd;
    bus.mc_data    = md;
    #1;
    if (!rstn) begin
      q.delete();
      m_we = 0; m_wr = '0; m_wd = '0; m_ready = 0;
    end else begin
      pipe_ok = pv && (prd != 5'd31);
      accept  = mv && m_ready;
      m_we    = 0;
      if (pipe_ok) begin
        m_we = 1; m_wr = prd; m_wd = pd;
        foreach (q[i]) if (q[i].rd == prd) q[i].live = 0;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.live) begin
          m_we = 1; m_wr = h.rd; m_wd = h.data;
        end
      end
      if (accept && (mrd != 5'd31)) q.push_back('{rd: mrd, data: md, live: 1'b1});
      m_ready = (q.size() < DEPTH);
`ifdef WB_BYPASS_EN
      check("bypass_valid", 64'(bus.bypass_valid), 64'(m_we));
      check("bypass_rd", 64'(bus.bypass_rd), 64'(m_wr));
      check("bypass_data", bus.bypass_data, m_wd);
`endif
    end
    @(posedge clk);
    @(negedge clk);
    check("RegWrite", 64'(bus.RegWrite), 64'(m_we));
    check("WriteRegister", 64'(bus.WriteRegister), 64'(m_wr));
    check("WriteData", bus.WriteData, m_wd);
    check("mc_ready", 64'(bus.mc_ready), 64'(m_ready));
    check("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    check("pending_mask", 64'(bus.pending_mask), 64'(m_pending()));
    check("no_x31_write", 64'(bus.RegWrite && (bus.WriteRegister == 5'd31)), 64'd0);
    if (bus.RegWrite) $display("t=%0t write x%0d <= %h", $time, bus.WriteRegister, bus.WriteData);
  endtask

  task automatic idle();
    step(1, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
  endtask

  initial begin
    logic [63:0] rnd_data;
    int          pipe_pct;
    // Reset
    step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    check("rst_ready", 64'(bus.mc_ready), 64'd0);

    // 1: single pipe write, one-cycle latency
    step(1, 1, 5'd5, 64'hAB, 0, 5'd0, 64'd0);
    check("t1_we", 64'(bus.RegWrite), 64'd1);
    check("t1_rd", 64'(bus.WriteRegister), 64'd5);
    check("t1_data", bus.WriteData, 64'hAB);
    check("t1_ready", 64'(bus.mc_ready), 64'd1);
    idle();
    check("t1_we_off", 64'(bus.RegWrite), 64'd0);

    // 2: fill under pipe pressure, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 1, 5'd10, 64'h1000 + 64'(i), 1, 5'(i), 64'h2000 + 64'(i));
    check("t2_count", 64'(bus.fifo_count), 64'd4);
    check("t2_ready", 64'(bus.mc_ready), 64'd0);
    check("t2_mask", 64'(bus.pending_mask), 64'h1E);
    for (int i = 1; i <= 4; i++) begin
      idle();
      check("t2_drain_rd", 64'(bus.WriteRegister), 64'(i));
      check("t2_drain_data", bus.WriteData, 64'h2000 + 64'(i));
      check("t2_ready_after_pop", 64'(bus.mc_ready), 64'd1);
    end

    // 3: WAW squash of a queued X7
    step(1, 0, 5'd0, 64'd0, 1, 5'd7, 64'h7777_0000);
    check("t3_mask_set", 64'(bus.pending_mask), 64'h80);
    step(1, 1, 5'd7, 64'h77, 0, 5'd0, 64'd0);
    check("t3_mask_clr", 64'(bus.pending_mask), 64'h0);
    check("t3_pipe_data", bus.WriteData, 64'h77);
    idle();
    check("t3_squashed_pop", 64'(bus.RegWrite), 64'd0);
    check("t3_count", 64'(bus.fifo_count), 64'd0);

    // 4: X31 on both sources while X2 is queued
    step(1, 0, 5'd0, 64'd0, 1, 5'd2, 64'h22);
    step(1, 1, 5'd31, 64'hDEAD, 1, 5'd31, 64'hBEEF);
    check("t4_we", 64'(bus.RegWrite), 64'd1);
    check("t4_rd", 64'(bus.WriteRegister), 64'd2);
    check("t4_count", 64'(bus.fifo_count), 64'd0);

    // 5: concurrent push/pop at count 2 across pointer wrap
    step(1, 1, 5'd20, 64'h20, 1, 5'd11, 64'h11);
    step(1, 1, 5'd21, 64'h21, 1, 5'd12, 64'h12);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 5'd0, 64'd0, 1, 5'(13 + k), 64'h500 + 64'(k));
      check("t5_count", 64'(bus.fifo_count), 64'd2);
    end
    idle();
    idle();

    // 6: reset with three queued entries
    for (int i = 1; i <= 3; i++) step(1, 1, 5'd25, 64'h25, 1, 5'(i), 64'h600 + 64'(i));
    step(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
    check("t6_we", 64'(bus.RegWrite), 64'd0);
    check("t6_rd", 64'(bus.WriteRegister), 64'd0);
    check("t6_data", bus.WriteData, 64'd0);
    check("t6_count", 64'(bus.fifo_count), 64'd0);
    check("t6_ready", 64'(bus.mc_ready), 64'd0);
    idle();
    check("t6_ready_release", 64'(bus.mc_ready), 64'd1);
    idle();
    check("t6_no_write", 64'(bus.RegWrite), 64'd0);

    // Random traffic with varying pipe pressure and occasional resets
    pipe_pct = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) pipe_pct = (c % 180 == 0) ? 95 : ((c % 120 == 0) ? 15 : 50);
      rnd_data = {$urandom, $urandom};
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < pipe_pct),
           ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
           rnd_data,
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
           ~rnd_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
